// File: rtl/imem_loader.sv
// Instruction memory loader: receives a framed byte stream and writes
// 32-bit words to imem while the CPU is held in reset.
// Ports:
//   clk, reset             - clock, async active-high reset
//   start                  - pulse to begin a load (IDLE/DONE/ERR only)
//   rx_data/valid/ready    - byte stream handshake
//   imem_we/addr/wdata     - instruction memory write port
//   cpu_hold               - CPU reset (1 = held)
//   busy/done/error        - load status (done/error sticky until start)
//   words_loaded           - words written in current/last load
module imem_loader #(
    parameter int ADDR_WIDTH = 10,
    parameter int MAX_WORDS  = 1024
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    output logic                  rx_ready,
    output logic                  imem_we,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    output logic [31:0]           imem_wdata,
    output logic                  cpu_hold,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [15:0]           words_loaded
);

    typedef enum logic [2:0] {
        IDLE, LEN_LO, LEN_HI, PAYLOAD, WRITE, CHECK, DONE, ERR
    } state_t;

    localparam logic [16:0] MAX_N = 17'(MAX_WORDS);

    state_t                state_q, state_d;
    logic [15:0]           n_q, n_d;
    logic [23:0]           buf_q, buf_d;
    logic [1:0]            idx_q, idx_d;
    logic [7:0]            csum_q, csum_d;
    logic                  we_d;
    logic [ADDR_WIDTH-1:0] addr_d;
    logic [31:0]           wdata_d;
    logic                  hold_d, busy_d, done_d, err_d;
    logic [15:0]           wl_d;
    logic [15:0]           len_new;
    logic                  xfer;

    assign rx_ready = (state_q == LEN_LO) || (state_q == LEN_HI) ||
                      (state_q == PAYLOAD) || (state_q == CHECK);
    assign xfer     = rx_valid && rx_ready;
    assign len_new  = {rx_data, n_q[7:0]};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            n_q          <= '0;
            buf_q        <= '0;
            idx_q        <= '0;
            csum_q       <= '0;
            imem_we      <= 1'b0;
            imem_addr    <= '0;
            imem_wdata   <= '0;
            cpu_hold     <= 1'b1;
            busy         <= 1'b0;
            done         <= 1'b0;
            error        <= 1'b0;
            words_loaded <= '0;
        end else begin
            state_q      <= state_d;
            n_q          <= n_d;
            buf_q        <= buf_d;
            idx_q        <= idx_d;
            csum_q       <= csum_d;
            imem_we      <= we_d;
            imem_addr    <= addr_d;
            imem_wdata   <= wdata_d;
            cpu_hold     <= hold_d;
            busy         <= busy_d;
            done         <= done_d;
            error        <= err_d;
            words_loaded <= wl_d;
        end
    end

    always_comb begin
        state_d = state_q;
        n_d     = n_q;
        buf_d   = buf_q;
        idx_d   = idx_q;
        csum_d  = csum_q;
        we_d    = 1'b0;
        addr_d  = imem_addr;
        wdata_d = imem_wdata;
        hold_d  = cpu_hold;
        busy_d  = busy;
        done_d  = done;
        err_d   = error;
        wl_d    = words_loaded;
        unique case (state_q)
            IDLE, DONE, ERR: begin
                if (start) begin
                    state_d = LEN_LO;
                    done_d  = 1'b0;
                    err_d   = 1'b0;
                    wl_d    = '0;
                    csum_d  = '0;
                    idx_d   = '0;
                    hold_d  = 1'b1;
                    busy_d  = 1'b1;
                end
            end
            LEN_LO: begin
                if (xfer) begin
                    n_d[7:0] = rx_data;
                    state_d  = LEN_HI;
                end
            end
            LEN_HI: begin
                if (xfer) begin
                    n_d[15:8] = rx_data;
                    if (len_new == 16'd0) begin
                        state_d = CHECK;
                    end else if ({1'b0, len_new} > MAX_N) begin
                        state_d = ERR;
                        err_d   = 1'b1;
                        busy_d  = 1'b0;
                        hold_d  = 1'b1;
                    end else begin
                        state_d = PAYLOAD;
                    end
                end
            end
            PAYLOAD: begin
                if (xfer) begin
                    csum_d = csum_q ^ rx_data;
                    idx_d  = idx_q + 2'd1;
                    unique case (idx_q)
                        2'd0: buf_d[7:0]   = rx_data;
                        2'd1: buf_d[15:8]  = rx_data;
                        2'd2: buf_d[23:16] = rx_data;
                        2'd3: begin
                            // Last byte goes straight to the write port.
                            state_d = WRITE;
                            we_d    = 1'b1;
                            addr_d  = words_loaded[ADDR_WIDTH-1:0];
                            wdata_d = {rx_data, buf_q};
                        end
                    endcase
                end
            end
            WRITE: begin
                wl_d    = words_loaded + 16'd1;
                state_d = (wl_d == n_q) ? CHECK : PAYLOAD;
            end
            CHECK: begin
                if (xfer) begin
                    busy_d = 1'b0;
                    if (rx_data == csum_q) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                        hold_d  = 1'b0;
                    end else begin
                        state_d = ERR;
                        err_d   = 1'b1;
                        hold_d  = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
Byte-stream program loader that writes instruction memory while holding the pipelined CPU in reset. It accepts a framed byte stream over a valid/ready handshake: a length header, little-endian instruction words, then an XOR checksum. It assembles 32-bit words and writes them at word addresses 0..N-1, matching the CPU's word-granular PC (pc+1 per instruction). The CPU is released only after a good checksum.

Parameters:
ADDR_WIDTH, 10, instruction memory word-address width
MAX_WORDS, 1024, largest accepted word count (must be <= 2**ADDR_WIDTH)

Ports:
clk  input  1  clock
reset  input  1  asynchronous, active-high reset
start  input  1  single-cycle pulse; begins a new load
rx_data  input  8  stream byte
rx_valid  input  1  rx_data valid
rx_ready  output  1  loader can accept a byte
imem_we  output  1  instruction memory write strobe, one cycle per word
imem_addr  output  ADDR_WIDTH  word address of the write
imem_wdata  output  32  instruction word
cpu_hold  output  1  drives CPU reset; high = CPU held
busy  output  1  load in progress
done  output  1  last load succeeded; sticky until start
error  output  1  last load failed; sticky until start
words_loaded  output  16  words written in current/last load

Behaviour:
- Interface: reset reset, asynchronous, active-high; clock clk. All outputs registered except rx_ready, which decodes from state.
- Reset values: state IDLE, cpu_hold=1, imem_we=0, imem_addr=0, imem_wdata=0, busy=0, done=0, error=0, words_loaded=0, checksum=0, byte index=0.
- Byte transfer occurs on a cycle with rx_valid && rx_ready. rx_ready=1 only in LEN_LO, LEN_HI, PAYLOAD and CHECK. rx_valid may drop at any time; stalls are unbounded.
- States: IDLE, LEN_LO, LEN_HI, PAYLOAD, WRITE, CHECK, DONE, ERR.
- IDLE/DONE/ERR + start -> LEN_LO. This clears done, error, words_loaded, checksum and byte index, and sets cpu_hold=1 and busy=1. start in any other state is ignored.
- LEN_LO: accept byte -> N[7:0]. LEN_HI: accept byte -> N[15:8], then:
  - N==0 -> CHECK.
  - N>MAX_WORDS -> ERR.
  - otherwise -> PAYLOAD.
- PAYLOAD: each accepted byte is placed little-endian (byte index 0 -> bits 7:0 ... 3 -> bits 31:24) and XORed into checksum. On the 4th byte -> WRITE.
- WRITE (one cycle, rx_ready=0): imem_we=1, imem_addr=words_loaded[ADDR_WIDTH-1:0], imem_wdata=assembled word. Latency: 4th byte accepted at edge t, imem_we high during cycle t..t+1, deasserted the next cycle. words_loaded increments at the end of WRITE. Next state is CHECK if the incremented count == N, else PAYLOAD. Minimum throughput 5 cycles/word.
- CHECK: accept byte. Byte == checksum -> DONE; else -> ERR. Length bytes are not included in the checksum.
- DONE: cpu_hold=0, done=1, busy=0.
- ERR: cpu_hold=1, error=1, busy=0. The CPU stays held until a subsequent successful load.
- imem_we is never asserted outside WRITE. imem_addr/imem_wdata hold their last values otherwise.
- Reset mid-load: immediate return to reset values. Partially written memory contents are not cleared. cpu_hold stays 1.
- The byte index wraps 3->0 on each word. words_loaded never exceeds N.

Test Plan:
1. Good load: start, bytes 02 00 93 02 50 00 13 03 30 00 E1 with rx_valid continuous -> imem_we pulses twice: addr0=0x00500293, addr1=0x00300313; done=1, cpu_hold=0, error=0, words_loaded=2.
2. Bad checksum: same stream with last byte E0 -> both words written, then error=1, done=0, cpu_hold=1.
3. Zero length: start, 00 00 00 -> no imem_we, done=1, cpu_hold=0. Then 00 00 01 -> error=1.
4. Oversize: MAX_WORDS=1024, length bytes 01 04 (N=1025) -> ERR right after 2nd byte, rx_ready=0, no writes.
5. Backpressure/gaps: test-1 stream with rx_valid randomly low and a byte presented during WRITE -> byte not consumed until rx_ready=1; identical writes and result.
6. Reset mid-load and stray start: start pulse mid-payload ignored. Then reset after 5 payload bytes -> all outputs at reset values, cpu_hold=1. Fresh start + test-1 stream succeeds.
